// File: rtl/irq_pending_dispatcher.sv
// Interrupt front end: captures request events into a pending register,
// exposes the masked vector to an external priority encoder, and dispatches
// one id at a time to a service unit over a req/ack/done handshake.
module irq_pending_dispatcher #(
    parameter int unsigned N         = 8,
    parameter int unsigned ID_W      = 3,
    parameter int unsigned EDGE_MODE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    irq_in,
    input  logic [N-1:0]    irq_mask,
    output logic [N-1:0]    enc_in,
    output logic            enc_en,
    input  logic [ID_W-1:0] enc_out,
    input  logic            enc_valid,
    output logic            srv_req,
    output logic [ID_W-1:0] srv_id,
    input  logic            srv_ack,
    input  logic            srv_done,
    output logic            busy,
    output logic [N-1:0]    pending
);

    localparam int unsigned ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    pending_q, pending_d;
    logic [N-1:0]    irq_q;
    logic [N-1:0]    ev;
    logic [N-1:0]    clr;
    logic [ID_W-1:0] srv_id_q, srv_id_d;

    // Event detection: rising edge against last cycle's lines, or plain level.
    always_comb begin
        ev = irq_in;
        if (EDGE_MODE != 0) begin
            ev = irq_in & ~irq_q;
        end
    end

    // Clear mask for the serviced id, only in the cycle done is accepted.
    always_comb begin
        clr = '0;
        if ((state_q == ST_SERVICE) && srv_done) begin
            clr = N'(1) << srv_id_q;
        end
    end

    // Pending update: a new event on a bit being cleared wins.
    always_comb begin
        pending_d = (pending_q & ~clr) | ev;
    end

    // Dispatch FSM next-state and id capture.
    always_comb begin
        state_d  = state_q;
        srv_id_d = srv_id_q;
        unique case (state_q)
            ST_IDLE: begin
                if (enc_valid) begin
                    srv_id_d = enc_out;
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                if (srv_ack) begin
                    state_d = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (srv_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, pending, id and edge-history registers. Edge history resets to
    // all-ones so lines already high at reset release raise no event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            srv_id_q  <= '0;
            irq_q     <= '1;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            srv_id_q  <= srv_id_d;
            irq_q     <= irq_in;
        end
    end

    assign enc_in  = pending_q & irq_mask;
    assign enc_en  = (state_q == ST_IDLE);
    assign srv_req = (state_q == ST_REQ);
    assign busy    = (state_q != ST_IDLE);
    assign srv_id  = srv_id_q;
    assign pending = pending_q;

endmodule
